mem_responder: RTL and testbench

Memory-side responder for the single-cycle core's fetch and data ports. It accepts an instruction-fetch request and a data load/store request, arbitrates them onto one single-port synchronous SRAM with a fixed access latency, and returns read data with a one-cycle ready pulse per requester. It sits between the core (program counter / ALU address path) and the RAM macro, taking the place of a zero-wait memory model.

---
 rtl/mem_responder.sv | 108 ++++++++++
 tb/tb_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Arbitrates instruction-fetch and data requests onto one fixed-latency
// single-port SRAM, returning registered read data with a one-cycle ready pulse.
module mem_responder #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iren,
    input  logic [31:0]       iaddr,
    output logic [31:0]       iload,
    output logic              iready,
    input  logic              dren,
    input  logic              dwen,
    input  logic [31:0]       daddr,
    input  logic [31:0]       dstore,
    input  logic [3:0]        dbe,
    output logic [31:0]       dload,
    output logic              dready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_ren,
    output logic              ram_wen,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       owner_data, is_write, last_was_data;
    logic       grant_data, grant_fetch, grant_write;

    // Byte offset and bits above the SRAM window are dropped: addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iaddr[31:ADDR_W+2], iaddr[1:0], daddr[31:ADDR_W+2], daddr[1:0]};

    always_comb begin
        grant_data  = (dren | dwen) & ~(last_was_data & iren);
        grant_fetch = iren & ~grant_data;
        grant_write = grant_data & dwen;
        state_nxt   = state;
        case (state)
            IDLE:    if (grant_data | grant_fetch) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            owner_data    <= 1'b0;
            is_write      <= 1'b0;
            last_was_data <= 1'b0;
            iload         <= '0;
            dload         <= '0;
            iready        <= 1'b0;
            dready        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_be        <= '0;
            ram_ren       <= 1'b0;
            ram_wen       <= 1'b0;
        end else begin
            iready <= 1'b0;
            dready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data | grant_fetch) begin
                        owner_data <= grant_data;
                        is_write   <= grant_write;
                        ram_addr   <= grant_data ? daddr[ADDR_W+1:2] : iaddr[ADDR_W+1:2];
                        ram_wdata  <= dstore;
                        ram_be     <= grant_write ? dbe : 4'hF;
                        ram_ren    <= ~grant_write;
                        ram_wen    <= grant_write;
                        cnt        <= 4'(LATENCY);
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd1) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        iready  <= ~owner_data;
                        dready  <= owner_data;
                        if (!is_write) begin
                            if (owner_data) dload <= ram_rdata;
                            else            iload <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: last_was_data <= owner_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 2 and 1), a timeline model
// checked every cycle, and directed literal checks on key cycles.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        iren[2], dren[2], dwen[2];
    logic [31:0] iaddr[2], daddr[2], dstore[2], iload[2], dload[2];
    logic [3:0]  dbe[2], ram_be[2];
    logic        iready[2], dready[2], ram_ren[2], ram_wen[2];
    logic [15:0] ram_addr[2];
    logic [31:0] ram_wdata[2], ram_rdata[2];
    logic [31:0] mem[2][256];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign ram_rdata[g] = mem[g][ram_addr[g][7:0]];
        mem_responder #(.LATENCY(g == 0 ? 2 : 1), .ADDR_W(16)) dut (
            .clk(clk), .rst(rst),
            .iren(iren[g]), .iaddr(iaddr[g]), .iload(iload[g]), .iready(iready[g]),
            .dren(dren[g]), .dwen(dwen[g]), .daddr(daddr[g]), .dstore(dstore[g]),
            .dbe(dbe[g]), .dload(dload[g]), .dready(dready[g]),
            .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_be(ram_be[g]),
            .ram_ren(ram_ren[g]), .ram_wen(ram_wen[g]), .ram_rdata(ram_rdata[g]));
    end

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // SRAM contents: filled while reset is held, written by the DUT strobes.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= 32'hA500_0000 | 32'(i);
                mem[k][4] <= (k == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            end else if (ram_wen[k]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[k][b]) mem[k][ram_addr[k][7:0]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
            end
        end
    end

    // Model: one transaction record per instance, granted at cycle g_m.
    bit          act_m[2] = '{0, 0};
    int          g_m[2] = '{0, 0};
    bit          wr_m[2] = '{0, 0};
    bit          dat_m[2] = '{0, 0};
    bit          lwd_m[2] = '{0, 0};
    logic [15:0] ra_m[2] = '{16'h0, 16'h0};
    logic [31:0] wd_m[2] = '{32'h0, 32'h0};
    logic [31:0] il_m[2] = '{32'h0, 32'h0};
    logic [31:0] dl_m[2] = '{32'h0, 32'h0};
    logic [3:0]  be_m[2] = '{4'h0, 4'h0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act_m[k] <= 0; lwd_m[k] <= 0; ra_m[k] <= '0; wd_m[k] <= '0;
                il_m[k] <= '0; dl_m[k] <= '0; be_m[k] <= '0;
            end else if (act_m[k]) begin
                if (cyc == g_m[k] + lat(k) && !wr_m[k]) begin
                    if (dat_m[k]) dl_m[k] <= mem[k][ra_m[k][7:0]];
                    else          il_m[k] <= mem[k][ra_m[k][7:0]];
                end
                if (cyc == g_m[k] + lat(k) + 1) begin
                    act_m[k] <= 0;
                    lwd_m[k] <= dat_m[k];
                end
            end else begin
                bit gd, gf;
                gd = (dren[k] || dwen[k]) && !(lwd_m[k] && iren[k]);
                gf = iren[k] && !gd;
                if (gd || gf) begin
                    act_m[k] <= 1;
                    g_m[k]   <= cyc;
                    dat_m[k] <= gd;
                    wr_m[k]  <= gd && dwen[k];
                    ra_m[k]  <= gd ? daddr[k][17:2] : iaddr[k][17:2];
                    wd_m[k]  <= dstore[k];
                    be_m[k]  <= (gd && dwen[k]) ? dbe[k] : 4'hF;
                end
            end
        end
    end

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                bit acc, rdy;
                acc = act_m[k] && cyc >= g_m[k] + 1 && cyc <= g_m[k] + lat(k);
                rdy = act_m[k] && cyc == g_m[k] + lat(k) + 1;
                check("m_ram_ren", k, 32'(ram_ren[k]), 32'(acc && !wr_m[k]));
                check("m_ram_wen", k, 32'(ram_wen[k]), 32'(acc && wr_m[k]));
                check("m_iready", k, 32'(iready[k]), 32'(rdy && !dat_m[k]));
                check("m_dready", k, 32'(dready[k]), 32'(rdy && dat_m[k]));
                check("m_ram_addr", k, 32'(ram_addr[k]), 32'(ra_m[k]));
                check("m_ram_wdata", k, ram_wdata[k], wd_m[k]);
                check("m_ram_be", k, 32'(ram_be[k]), 32'(be_m[k]));
                check("m_iload", k, iload[k], il_m[k]);
                check("m_dload", k, dload[k], dl_m[k]);
            end
        end
    end

    task automatic at_pos(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        @(negedge clk);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iren[k] = 0; dren[k] = 0; dwen[k] = 0;
            iaddr[k] = '0; daddr[k] = '0; dstore[k] = '0; dbe[k] = '0;
        end
        wait_cyc(1);
        check("rst_ram_be", 0, 32'(ram_be[0]), 32'h0);
        check("rst_iload", 0, iload[0], 32'h0);
        check("rst_ren", 0, 32'(ram_ren[0]), 32'h0);
        at_pos(2); rst = 1'b0;

        // single fetch
        at_pos(3); iren[0] = 1; iaddr[0] = 32'h10;
        wait_cyc(4); check("f_ren", 0, 32'(ram_ren[0]), 32'h1); check("f_addr", 0, 32'(ram_addr[0]), 32'h4);
        wait_cyc(5); check("f_ren2", 0, 32'(ram_ren[0]), 32'h1);
        wait_cyc(6); check("f_iready", 0, 32'(iready[0]), 32'h1); check("f_iload", 0, iload[0], 32'hDEAD_BEEF);
        at_pos(7); iren[0] = 0;
        wait_cyc(7); check("f_iready_off", 0, 32'(iready[0]), 32'h0);

        // store with byte enables
        at_pos(9); dwen[0] = 1; daddr[0] = 32'h20; dstore[0] = 32'h1122_3344; dbe[0] = 4'b0011;
        wait_cyc(10); check("s_wen", 0, 32'(ram_wen[0]), 32'h1); check("s_addr", 0, 32'(ram_addr[0]), 32'h8);
        check("s_be", 0, 32'(ram_be[0]), 32'h3);
        wait_cyc(11); check("s_wen2", 0, 32'(ram_wen[0]), 32'h1);
        wait_cyc(12); check("s_dready", 0, 32'(dready[0]), 32'h1); check("s_dload", 0, dload[0], 32'h0);
        at_pos(13); dwen[0] = 0;

        // read and write together is a write
        at_pos(15); dren[0] = 1; dwen[0] = 1; daddr[0] = 32'h40; dstore[0] = 32'hCAFE_F00D; dbe[0] = 4'hF;
        wait_cyc(16); check("rw_ren", 0, 32'(ram_ren[0]), 32'h0); check("rw_wen", 0, 32'(ram_wen[0]), 32'h1);
        wait_cyc(18); check("rw_dready", 0, 32'(dready[0]), 32'h1); check("rw_dload", 0, dload[0], 32'h0);
        at_pos(19); dren[0] = 0; dwen[0] = 0;

        // read back the partial store, then fetch the full-word store
        at_pos(21); dren[0] = 1; daddr[0] = 32'h20;
        wait_cyc(24); check("r_dload", 0, dload[0], 32'hA500_3344);
        at_pos(25); dren[0] = 0;
        at_pos(27); iren[0] = 1; iaddr[0] = 32'h40;
        wait_cyc(30); check("r_iload", 0, iload[0], 32'hCAFE_F00D);
        at_pos(31); iren[0] = 0;

        // contention: data, fetch, data
        at_pos(33); iren[0] = 1; iaddr[0] = 32'h10; dren[0] = 1; daddr[0] = 32'h20;
        wait_cyc(36); check("a_dready1", 0, 32'(dready[0]), 32'h1); check("a_iready1", 0, 32'(iready[0]), 32'h0);
        wait_cyc(40); check("a_iready2", 0, 32'(iready[0]), 32'h1); check("a_dready2", 0, 32'(dready[0]), 32'h0);
        check("a_iload", 0, iload[0], 32'hDEAD_BEEF);
        wait_cyc(44); check("a_dready3", 0, 32'(dready[0]), 32'h1);
        at_pos(45); iren[0] = 0; dren[0] = 0;

        // reset mid-fetch
        at_pos(47); iren[0] = 1; iaddr[0] = 32'h10;
        wait_cyc(48); check("x_ren", 0, 32'(ram_ren[0]), 32'h1);
        at_pos(49); rst = 1'b1; iren[0] = 0;
        #1;
        check("x_ren_drop", 0, 32'(ram_ren[0]), 32'h0);
        check("x_iready", 0, 32'(iready[0]), 32'h0);
        check("x_iload", 0, iload[0], 32'h0);
        at_pos(50); rst = 1'b0;
        at_pos(51); iren[0] = 1; iaddr[0] = 32'h10;
        wait_cyc(54); check("x_iready2", 0, 32'(iready[0]), 32'h1); check("x_iload2", 0, iload[0], 32'hDEAD_BEEF);
        at_pos(55); iren[0] = 0;

        // LATENCY=1, misaligned address, back-to-back fetches
        at_pos(57); iren[1] = 1; iaddr[1] = 32'h13;
        wait_cyc(58); check("l1_ren", 1, 32'(ram_ren[1]), 32'h1); check("l1_addr", 1, 32'(ram_addr[1]), 32'h4);
        wait_cyc(59); check("l1_iready", 1, 32'(iready[1]), 32'h1); check("l1_iload", 1, iload[1], 32'h0BAD_F00D);
        wait_cyc(60); check("l1_gap", 1, 32'(iready[1]), 32'h0);
        wait_cyc(62); check("l1_iready2", 1, 32'(iready[1]), 32'h1);
        wait_cyc(65); check("l1_iready3", 1, 32'(iready[1]), 32'h1);
        at_pos(66); iren[1] = 0;

        wait_cyc(70);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
